// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and helpers for the pipelined ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    // Bits of the carry chain handled by one pipeline segment.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: combinational SEG-bit ripple-carry slice built from per-bit
// full-adder cells; one instance closes one pipeline segment of pipe_adder.
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = seg_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // c[i] is the carry into bit i; c[SEG] leaves the segment.
    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder whose carry chain is cut into STAGES registered
// segments, with valid/ready handshakes on both sides and a global stall.
// Optional feature: define PIPE_ADDER_OVF_EN to add the registered signed
// overflow output ovf.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Guarded so a bad STAGES does not divide by zero before the error fires.
    localparam int SEG = (STAGES > 0) ? seg_width(WIDTH, STAGES) : 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: need WIDTH>=1, 1<=STAGES<=WIDTH and WIDTH%%STAGES==0");
    end

    // The whole pipeline moves together; a stalled output freezes every stage.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        // Inputs of this segment: either the ports or the previous stage register.
        logic                v_in;
        logic                c_in;
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic [SEG-1:0]      s_seg;
        logic                c_seg;
        logic [HI-1:0]       s_nxt;

        // Stage register: valid, completed low sum bits and outgoing carry.
        logic                vld_p;
        logic [HI-1:0]       sum_p;
        logic                cy_p;

        if (k == 0) begin : g_head
            assign v_in  = in_valid;
            assign c_in  = cin;
            assign a_in  = a;
            assign b_in  = b;
            assign s_nxt = s_seg;
        end else begin : g_body
            assign v_in  = g_st[k-1].vld_p;
            assign c_in  = g_st[k-1].cy_p;
            assign a_in  = g_st[k-1].g_fwd.a_up_p;
            assign b_in  = g_st[k-1].g_fwd.b_up_p;
            assign s_nxt = {s_seg, g_st[k-1].sum_p};
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (a_in[SEG-1:0]),
            .b    (b_in[SEG-1:0]),
            .cin  (c_in),
            .sum  (s_seg),
            .cout (c_seg)
        );

        // Slot occupancy: bubbles travel as invalid slots, never collapsed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (adv) begin
                vld_p <= v_in;
            end
        end

        if (k == STAGES - 1) begin : g_tail
            // Output data register, cleared so sum/cout read zero out of reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_p <= '0;
                    cy_p  <= 1'b0;
                end else if (adv) begin
                    sum_p <= s_nxt;
                    cy_p  <= c_seg;
                end
            end

`ifdef PIPE_ADDER_OVF_EN
            // The sign bits reach here as the top bits of the forwarded operands.
            logic ovf_p;

            // Signed overflow: equal operand signs but a different result sign.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_p <= 1'b0;
                end else if (adv) begin
                    ovf_p <= (a_in[SEG-1] == b_in[SEG-1]) && (s_seg[SEG-1] != a_in[SEG-1]);
                end
            end
`endif
        end else begin : g_fwd
            // Operand bits not yet added, carried forward untouched.
            logic [WIDTH-HI-1:0] a_up_p;
            logic [WIDTH-HI-1:0] b_up_p;

            // Inner stage data: partial sum, carry and the pending upper operands.
            always_ff @(posedge clk) begin
                if (adv) begin
                    sum_p  <= s_nxt;
                    cy_p   <= c_seg;
                    a_up_p <= a_in[WIDTH-LO-1:SEG];
                    b_up_p <= b_in[WIDTH-LO-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_p;
    assign sum       = g_st[STAGES-1].sum_p;
    assign cout      = g_st[STAGES-1].cy_p;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = g_st[STAGES-1].g_tail.ovf_p;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder. Three instances (STAGES=2,1,8,
// WIDTH=8) share the bench; directed cases run on the STAGES=2 instance, then
// all three take random operands with random valid/ready.
`timescale 1ns/1ps
module tb_pipe_adder;

    localparam int NI = 3;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [W-1:0] a_s    [NI];
    logic [W-1:0] b_s    [NI];
    logic         cin_s  [NI];
    logic         iv_s   [NI];
    logic         ir_s   [NI];
    logic [W-1:0] sum_s  [NI];
    logic         cout_s [NI];
    logic         ov_s   [NI];
    logic         or_s   [NI];
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf_s  [NI];
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           c0;
        int           st0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   stc [NI];
    int   acc [NI];

    function automatic int stg(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 8);
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        pipe_adder #(
            .WIDTH  (W),
            .STAGES (stg(i))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a_s[i]),
            .b         (b_s[i]),
            .cin       (cin_s[i]),
            .in_valid  (iv_s[i]),
            .in_ready  (ir_s[i]),
            .sum       (sum_s[i]),
            .cout      (cout_s[i]),
            .out_valid (ov_s[i]),
            .out_ready (or_s[i])
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf       (ovf_s[i])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the accepted operands.
    task automatic push(input int i);
        exp_t e;
        int   u;
        int   sa;
        int   sb;
        int   r;
        u  = int'(a_s[i]) + int'(b_s[i]) + int'(cin_s[i]);
        sa = (int'(a_s[i]) >= 128) ? int'(a_s[i]) - 256 : int'(a_s[i]);
        sb = (int'(b_s[i]) >= 128) ? int'(b_s[i]) - 256 : int'(b_s[i]);
        r  = sa + sb + int'(cin_s[i]);
        e.sum  = W'(u % 256);
        e.cout = (u >= 256);
        e.ovf  = (r > 127) || (r < -128);
        e.c0   = cyc;
        e.st0  = stc[i];
        acc[i]++;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic retire(input int i);
        exp_t e;
        bit   ok;
        ok = 1'b1;
        case (i)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d_spurious: got result 0x%0h with nothing outstanding", i, sum_s[i]);
        end else begin
            check($sformatf("u%0d_sum", i), sum_s[i], e.sum);
            check($sformatf("u%0d_cout", i), cout_s[i], e.cout);
            check($sformatf("u%0d_latency", i), cyc - e.c0, stg(i) + stc[i] - e.st0);
`ifdef PIPE_ADDER_OVF_EN
            check($sformatf("u%0d_ovf", i), ovf_s[i], e.ovf);
`endif
        end
    endtask

    // Output monitor: retires a result on every output handshake, counts stalls.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int i = 0; i < NI; i++) begin
                if (ov_s[i] === 1'b1) begin
                    if (or_s[i] === 1'b1) retire(i);
                    else stc[i]++;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic c, input logic r);
        iv_s[i]  = v;
        a_s[i]   = av;
        b_s[i]   = bv;
        cin_s[i] = c;
        or_s[i]  = r;
    endtask

    task automatic commit();
        #1;
        for (int i = 0; i < NI; i++) begin
            if (iv_s[i] === 1'b1 && ir_s[i] === 1'b1) push(i);
        end
    endtask

    // Three back-to-back operands on instance 0, then checks of the three results.
    task automatic stream3(input string tag, input logic [W-1:0] ta [3], input logic [W-1:0] tb [3],
                           input logic tc [3], input logic [W-1:0] es [3], input logic ec [3],
                           input logic eo [3]);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(0, 1'b1, ta[k], tb[k], tc[k], 1'b1);
            else       drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
            commit();
            if (k >= 2) begin
                check($sformatf("%s_valid%0d", tag, k - 2), ov_s[0], 1);
                check($sformatf("%s_sum%0d", tag, k - 2), sum_s[0], es[k-2]);
                check($sformatf("%s_cout%0d", tag, k - 2), cout_s[0], ec[k-2]);
`ifdef PIPE_ADDER_OVF_EN
                check($sformatf("%s_ovf%0d", tag, k - 2), ovf_s[0], eo[k-2]);
`else
                if (eo[k-2] !== 1'bx) begin end
`endif
            end
            next_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic         tc [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        logic         eo [3];
        int           guard;
        bit           done;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            drive(i, 1'b0, '0, '0, 1'b0, 1'b1);
            stc[i] = 0;
            acc[i] = 0;
        end
        repeat (3) next_cycle();

        // Reset state
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d_rst_out_valid", i), ov_s[i], 0);
            check($sformatf("u%0d_rst_sum", i), sum_s[i], 0);
            check($sformatf("u%0d_rst_in_ready", i), ir_s[i], 1);
        end
        check("rst_cout", cout_s[0], 0);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", ovf_s[0], 0);
`endif
        rst = 1'b0;
        next_cycle();

        // Carry ripple across the segment boundary, single-cycle output pulse
        drive(0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        commit();
        next_cycle();
        drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
        commit();
        check("ripple_not_yet", ov_s[0], 0);
        next_cycle();
        check("ripple_valid", ov_s[0], 1);
        check("ripple_sum", sum_s[0], 8'h00);
        check("ripple_cout", cout_s[0], 1);
        next_cycle();
        check("ripple_one_pulse", ov_s[0], 0);

        // Streaming, one result per cycle
        ta = '{8'h10, 8'h0F, 8'hF0};
        tb = '{8'h20, 8'h01, 8'h10};
        tc = '{1'b0, 1'b1, 1'b0};
        es = '{8'h30, 8'h11, 8'h00};
        ec = '{1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b0};
        stream3("stream", ta, tb, tc, es, ec, eo);

        // Signed overflow corners
        ta = '{8'h7F, 8'h80, 8'hFF};
        tb = '{8'h01, 8'h80, 8'h01};
        tc = '{1'b0, 1'b0, 1'b0};
        es = '{8'h80, 8'h00, 8'h00};
        ec = '{1'b0, 1'b1, 1'b1};
        eo = '{1'b1, 1'b1, 1'b0};
        stream3("ovf", ta, tb, tc, es, ec, eo);

        // Backpressure: three stalled cycles with a further operand offered
        drive(0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1);
        commit();
        next_cycle();
        drive(0, 1'b1, 8'hAA, 8'h66, 1'b0, 1'b1);
        commit();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0);
            commit();
            check($sformatf("bp_in_ready%0d", k), ir_s[0], 0);
            check($sformatf("bp_valid%0d", k), ov_s[0], 1);
            check($sformatf("bp_sum%0d", k), sum_s[0], 8'h47);
            check($sformatf("bp_cout%0d", k), cout_s[0], 0);
            next_cycle();
        end
        drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
        commit();
        check("bp_release_sum", sum_s[0], 8'h47);
        next_cycle();
        check("bp_drain_valid", ov_s[0], 1);
        check("bp_drain_sum", sum_s[0], 8'h10);
        check("bp_drain_cout", cout_s[0], 1);
        next_cycle();
        check("bp_nothing_extra", ov_s[0], 0);

        // Asynchronous reset with two results in flight
        drive(0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
        commit();
        next_cycle();
        drive(0, 1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
        commit();
        next_cycle();
        drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
        commit();
        check("rstmid_before", ov_s[0], 1);
        #1;
        rst = 1'b1;
        q0.delete();
        #1;
        check("rstmid_valid", ov_s[0], 0);
        check("rstmid_sum", sum_s[0], 0);
        check("rstmid_in_ready", ir_s[0], 1);
        next_cycle();
        rst = 1'b0;
        drive(0, 1'b1, 8'd3, 8'd4, 1'b0, 1'b1);
        commit();
        next_cycle();
        drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
        commit();
        check("rstmid_after_early", ov_s[0], 0);
        next_cycle();
        check("rstmid_after_valid", ov_s[0], 1);
        check("rstmid_after_sum", sum_s[0], 8'd7);
        next_cycle();

        // Random operands with random valid/ready on all three instances
        for (int i = 0; i < NI; i++) acc[i] = 0;
        for (guard = 0; guard < 8000; guard++) begin
            done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (acc[i] < 1000) begin
                    done = 1'b0;
                    drive(i, ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
                end else begin
                    drive(i, 1'b0, '0, '0, 1'b0, 1'b1);
                end
            end
            if (done) break;
            commit();
            next_cycle();
        end
        for (int i = 0; i < NI; i++) drive(i, 1'b0, '0, '0, 1'b0, 1'b1);
        repeat (20) next_cycle();
        for (int i = 0; i < NI; i++) check($sformatf("u%0d_accepted", i), acc[i], 1000);
        check("u0_drained", q0.size(), 0);
        check("u1_drained", q1.size(), 0);
        check("u2_drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder with carry-in, carry-out and a valid/ready handshake on both sides. It generalises the single-bit sum/carry cell to a WIDTH-bit operand pair. The carry chain is split into STAGES registered segments, so the adder closes timing at wide widths. It is the arithmetic building block for the team's datapath and ALU exercises, and sits between an operand producer and a result consumer.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥1.
- STAGES, 2: number of pipeline segments; 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0 (elaboration-time `$error` otherwise).
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- A  input  WIDTH  operand A, unsigned (two's complement for OVF).
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in.
- IN_VALID  input  1  A/B/CIN valid this cycle.
- IN_READY  output  1  block accepts the operand this cycle.
- SUM  output  WIDTH  A + B + CIN, low WIDTH bits.
- COUT  output  1  carry out of bit WIDTH-1.
- OUT_VALID  output  1  SUM/COUT hold a result.
- OUT_READY  input  1  consumer takes the result this cycle.
- OVF  output  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Segment width SEG = WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] of A and B, plus the carry registered by stage k-1. Stage 0 uses CIN.
- Each stage register holds:
  - valid bit
  - completed low sum bits
  - outgoing carry
  - not-yet-added upper A/B bits, passed forward untouched.
- Global advance: ADV = !OUT_VALID || OUT_READY. All stage registers load only when ADV=1, and hold otherwise.
- IN_READY = ADV (combinational). An operand is accepted iff IN_VALID && IN_READY.
- Stage 0 valid loads IN_VALID when ADV, so bubbles propagate as invalid slots. A bubble in a stage does not let earlier stages skip ahead (no bubble collapse).
- OUT_VALID is the valid bit of the last stage. SUM/COUT are its registered contents.
- Results leave in acceptance order. No drop, no duplication.
- Arithmetic is unsigned modulo 2^WIDTH. COUT is bit WIDTH of the full (WIDTH+1)-bit result.
- While OUT_VALID && !OUT_READY, SUM/COUT/OVF are held stable and IN_READY=0.
- Data in invalid slots is don't-care. Bench checks SUM/COUT only when OUT_VALID=1.

## Timing
- Latency: an operand accepted at edge n appears with OUT_VALID=1 after edge n+STAGES−1. It is visible in the cycle following edge n+STAGES−1 (i.e. STAGES cycles from acceptance), given no stall.
- Throughput: one result per cycle while OUT_READY=1.
- Stall: OUT_READY=0 with OUT_VALID=1 freezes the entire pipeline that cycle.
- Reset values: all stage valid bits 0; OUT_VALID=0, SUM=0, COUT=0, OVF=0. IN_READY=1 is a combinational result, since OUT_VALID=0.
- Reset mid-operation: in-flight results are discarded immediately (asynchronous). The first post-reset acceptance follows the normal latency.
- Simultaneous output pop and input push in the same cycle is legal and does not lose data.
- STAGES=1: a single register level. Latency 1, with the full ripple carry in one cycle.

## Configuration
- PIPE_ADDER_OVF_EN defined:
  - OVF port exists.
  - OVF = (A[W-1]==B[W-1]) && (SUM[W-1]!=A[W-1]), computed in the last stage from the carried sign bits.
  - OVF is registered alongside SUM and obeys the same valid/stall rules.
- PIPE_ADDER_OVF_EN not defined: no OVF port and no sign-bit storage. The rest of the behaviour is identical.

## Structure
- Package adder_pkg holds:
  - DEFAULT_WIDTH = 8 and DEFAULT_STAGES = 2.
  - function seg_width(WIDTH, STAGES) returning WIDTH/STAGES.
- Sub-module adder_segment, combinational:
  - Inputs: SEG-bit A, SEG-bit B, CIN.
  - Outputs: SEG-bit SUM, COUT.
  - Built as a chain of per-bit full-adder logic (sum = a^b^c, carry = a&b | c&(a^b)).
  - pipe_adder instantiates one adder_segment per stage via generate.

## Test plan
- Carry ripple across segments: WIDTH=8, STAGES=2, OUT_READY=1, accept A=0xFF, B=0x01, CIN=0 → STAGES cycles later SUM=0x00, COUT=1, OUT_VALID=1 for exactly one cycle.
- Streaming: push (0x10,0x20,0), (0x0F,0x01,1), (0xF0,0x10,0) on consecutive cycles → consecutive outputs 0x30/0, 0x11/0, 0x00/1, in order.
- Backpressure: with a result valid, hold OUT_READY=0 for 3 cycles → SUM/COUT stable, IN_READY=0, no new acceptance; release → remaining results drain in order, none lost.
- Reset mid-operation: assert RST asynchronously with two results in flight → OUT_VALID=0 and SUM=0 immediately; after release, A=3, B=4 yields SUM=7 at normal latency.
- OVF (macro defined):
  - 0x7F+0x01 → SUM=0x80, COUT=0, OVF=1.
  - 0x80+0x80 → SUM=0x00, COUT=1, OVF=1.
  - 0xFF+0x01 → OVF=0.
- Parameter sweep: STAGES=1 and STAGES=8 with WIDTH=8, 1000 random operands with random IN_VALID/OUT_READY → all results match the (WIDTH+1)-bit reference sum, and latency equals STAGES.
